// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator and instruction-memory requester.
// Holds the architectural fetch PC, issues requests that stay stable until
// acknowledged, and captures fetched words into a one-entry IF/ID register.
//
// Handshakes:
//   imem: imem_ren/imem_addr are held constant while a request is outstanding
//         (BUSY/DROP); a request completes in any cycle where imem_ren and
//         imem_ack are both high.
//   IF/ID: a transfer occurs in any cycle where if_valid and if_ready are both
//          high; if_valid never drops without a transfer or a flush.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] fetch_pc,
    input  logic [31:0] fetch_target,
    input  logic        fetch_predict,
    input  logic        mem_flush,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_target,
    output logic        if_predict,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] itgt_q, itgt_d;
    logic        ipred_q, ipred_d;

    logic        slot_ok;
    logic        req;
    logic        capture;
    logic [31:0] next_pc;

    // Request generation: IDLE issues only when the output slot can take a
    // word and no flush is pending; outstanding requests are held until ack.
    always_comb begin
        slot_ok = !valid_q || if_ready;
        next_pc = fetch_predict ? fetch_target : pc_q + 32'd4;
        case (state_q)
            ST_IDLE: req = slot_ok && !mem_flush;
            ST_BUSY: req = 1'b1;
            ST_DROP: req = 1'b1;
            default: req = 1'b0;
        endcase
    end

    // Next-state, PC selection and IF/ID register update; flush dominates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        itgt_d  = itgt_q;
        ipred_d = ipred_q;
        capture = 1'b0;

        if (mem_flush) begin
            valid_d = 1'b0;
            case (state_q)
                ST_IDLE: pc_d = fetch_target;
                ST_BUSY: begin
                    if (imem_ack) begin
                        pc_d    = fetch_target;
                        state_d = ST_IDLE;
                    end else begin
                        redir_d = fetch_target;
                        state_d = ST_DROP;
                    end
                end
                ST_DROP: begin
                    redir_d = fetch_target;
                    if (imem_ack) begin
                        pc_d    = fetch_target;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (imem_ack) capture = 1'b1;
                        else          state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (imem_ack) begin
                        capture = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    // Stale word for the pre-flush address: discard it.
                    if (imem_ack) begin
                        pc_d    = redir_q;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (capture) begin
                valid_d = 1'b1;
                inst_d  = imem_rdata;
                ipc_d   = pc_q;
                itgt_d  = next_pc;
                ipred_d = fetch_predict;
                pc_d    = next_pc;
            end else if (valid_q && if_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            redir_q <= 32'h0;
            valid_q <= 1'b0;
            inst_q  <= 32'h0;
            ipc_q   <= 32'h0;
            itgt_q  <= 32'h0;
            ipred_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            itgt_q  <= itgt_d;
            ipred_q <= ipred_d;
        end
    end

    // Reset gates the request combinationally so it drops immediately.
    assign imem_ren   = req && !rst;
    assign imem_addr  = pc_q;
    assign fetch_pc   = pc_q;
    assign if_valid   = valid_q;
    assign if_inst    = inst_q;
    assign if_pc      = ipc_q;
    assign if_target  = itgt_q;
    assign if_predict = ipred_q;
    assign dbg_state  = state_q;

endmodule
